// File: rtl/controlador_sinc_vga.sv
// VGA timing generator: pixel-rate divider, horizontal/vertical counters and
// registered sync / visible-area decode for the pixel and colour generator.
module controlador_sinc_vga #(
    parameter int DIV       = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pixel_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       Hsinc,
    output logic       Vsinc,
    output logic       video_on,
    output logic       fin_cuadro
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST     = DW'(DIV - 1);
    localparam logic [9:0]    H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0]    H_VIS_END    = 10'(H_VISIBLE);
    localparam logic [9:0]    V_VIS_END    = 10'(V_VISIBLE);
    localparam logic [9:0]    H_SYNC_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0]    H_SYNC_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0]    V_SYNC_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0]    V_SYNC_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [DW-1:0] divider;
    logic [DW-1:0] divider_next;
    logic          tick_next;
    logic [9:0]    x_next;
    logic [9:0]    y_next;
    logic          fin_next;
    logic          hsinc_next;
    logic          vsinc_next;
    logic          video_next;

    // The tick is registered, so it is derived from the divider's next value
    // to land in the same clk in which the divider holds DIV-1.
    always_comb begin
        divider_next = '0;
        if (divider != DIV_LAST) begin
            divider_next = divider + 1'b1;
        end
        tick_next = (divider_next == DIV_LAST);
    end

    always_comb begin
        x_next = pixel_x;
        y_next = pixel_y;
        if (pixel_tick) begin
            if (pixel_x == H_LAST) begin
                x_next = '0;
                if (pixel_y == V_LAST) begin
                    y_next = '0;
                end else begin
                    y_next = pixel_y + 10'd1;
                end
            end else begin
                x_next = pixel_x + 10'd1;
            end
        end
    end

    // fin_cuadro lines up with the tick that will wrap the frame.
    always_comb begin
        fin_next = tick_next && (x_next == H_LAST) && (y_next == V_LAST);
    end

    // Decode looks at the current counters, hence one clk behind them.
    always_comb begin
        hsinc_next = !((pixel_x >= H_SYNC_FIRST) && (pixel_x <= H_SYNC_LAST));
        vsinc_next = !((pixel_y >= V_SYNC_FIRST) && (pixel_y <= V_SYNC_LAST));
        video_next = (pixel_x < H_VIS_END) && (pixel_y < V_VIS_END);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            divider    <= '0;
            pixel_tick <= 1'b0;
            pixel_x    <= '0;
            pixel_y    <= '0;
            Hsinc      <= 1'b1;
            Vsinc      <= 1'b1;
            video_on   <= 1'b0;
            fin_cuadro <= 1'b0;
        end else begin
            divider    <= divider_next;
            pixel_tick <= tick_next;
            pixel_x    <= x_next;
            pixel_y    <= y_next;
            Hsinc      <= hsinc_next;
            Vsinc      <= vsinc_next;
            video_on   <= video_next;
            fin_cuadro <= fin_next;
        end
    end

endmodule
